srl_update_engine: RTL and testbench
====================================

# srl_update_engine

Parametrised serial-update engine for SRL-based CAM storage columns. It holds NUM_COL shift-register columns of DEPTH bits each, sharing one serial data input. It accepts a word-parallel load request with a column mask, then serialises the word into the selected columns over DEPTH cycles. Every column also provides an addressed read tap and a last-stage tap. It sits between the rule-update controller and the FractCAM match array, replacing the fixed 8×32 shift-column bank.

## Interface
Parameters:
- NUM_COL, 8: number of shift columns; 1..64.
- DEPTH, 32: bits per column; 16 or 32.
- ADDR_W, $clog2(DEPTH): read-address width; derived, not overridden.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  load request valid.
- wr_ready  output  1  engine can accept a request.
- wr_col_mask  input  NUM_COL  bit c=1 loads column c.
- wr_data  input  DEPTH  word to load; entry k of each selected column ends equal to wr_data[k].
- rd_addr  input  ADDR_W  read tap address, shared by all columns.
- rd_data  output  NUM_COL  entry rd_addr of each column, combinational from storage.
- q_last  output  NUM_COL  entry DEPTH-1 of each column (cascade tap).
- busy  output  1  high while a load is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse when a load completes.

## Operation
- Storage: per column c, bits s[c][0..DEPTH-1]. A shift on column c does s[c][0]<=din and s[c][i]<=s[c][i-1]. Column c shifts only when its enable bit is set.
- Storage has no reset and initialises to all zeros at configuration, matching SRL inference. rst does not change stored bits.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: wr_ready=1, busy=0.
  - On wr_valid && wr_ready, latch wr_col_mask into mask_r and wr_data into buf_r, clear cnt, and go to SHIFT.
  - With wr_valid low, stay in IDLE.
- SHIFT: wr_ready=0, busy=1.
  - Each cycle: column enable = mask_r, din = buf_r[DEPTH-1-cnt], cnt++.
  - When cnt==DEPTH-1 on a shift edge, go to DONE. That is the final shift, which writes buf_r[0].
  - Shift order is MSB first, so after DEPTH shifts s[c][k]=wr_data[k].
- DONE: no shift, done=1, busy=1, wr_ready=0. Next edge goes to IDLE.
- Unselected columns hold their contents unchanged through the whole load.
- mask=0 is accepted and runs the full sequence with no column shifting. done still pulses.
- wr_data and wr_col_mask are sampled only at acceptance. Changes after acceptance are ignored.
- cnt width is ADDR_W. It does not wrap within a load.

## Timing
- Reset values: FSM=IDLE, wr_ready=1, busy=0, done=0, cnt=0, mask_r=0, buf_r=0.
- rd_data and q_last reflect storage, all 0 after configuration.
- If acceptance happens at edge T:
  - shifts occur at edges T+1 .. T+DEPTH;
  - done=1 during the cycle after edge T+DEPTH;
  - wr_ready=1 again after edge T+DEPTH+1.
- Throughput: one load per DEPTH+2 cycles.
- rd_data and q_last show partially shifted values during SHIFT. Consumers must qualify reads with !busy.
- rd_data has zero latency: combinational from rd_addr and storage. Storage updates are visible the cycle after the shifting edge.
- rst asserted mid-load:
  - the FSM returns to IDLE at that edge;
  - no further shifts occur;
  - done is not pulsed;
  - the selected columns keep their partially shifted contents and must be reloaded.
- A request with wr_valid high during SHIFT or DONE is not accepted. It is held by the requester until wr_ready.

## Test plan
- Reset and idle: assert rst 2 cycles, then release. wr_ready=1, busy=0, done=0, rd_data=0 for all rd_addr, q_last=0.
- Single-column load (DEPTH=32):
  - stimulus: mask=8'h01, data=32'hA5C3_0F91;
  - required: done seen exactly 33 cycles after the acceptance edge;
  - required: sweeping rd_addr 0..31 gives column-0 bits equal to data bits;
  - required: q_last[0]=data[31]=1, and columns 1..7 remain 0.
- Multi-column masked load:
  - stimulus: preload all columns with 32'hFFFF_FFFF, then load mask=8'hA0 with data=32'h0000_0001;
  - required: columns 5 and 7 read 32'h1;
  - required: the other columns read 32'hFFFF_FFFF.
- Back-to-back requests with wr_valid held high:
  - stimulus: two requests, mask 8'h03 then 8'h0C;
  - required: second acceptance occurs exactly 34 cycles after the first;
  - required: data changes on wr_data during SHIFT have no effect.
- Zero mask:
  - stimulus: mask=0, data=32'hDEAD_BEEF;
  - required: done pulses after 33 cycles and storage is unchanged.
- Mid-load reset:
  - stimulus: assert rst at shift 10 of a mask=8'h01 load;
  - required: next cycle wr_ready=1, busy=0, no done pulse;
  - required: a following full load of 32'h1234_5678 reads back exactly.
- Parameter sweep: repeat the single-column load with NUM_COL=1, 64 and DEPTH=16. Latency is DEPTH+1 cycles to done.

Source files
------------

// File: rtl/srl_update_engine.sv
// srl_update_engine
// NUM_COL shift-register (SRL-style) storage columns of DEPTH bits that share one
// serial data input. A word-parallel load request with a column mask is serialised
// MSB first into the selected columns over DEPTH cycles. Every column exposes an
// addressed read tap (rd_data) and a last-stage cascade tap (q_last).
module srl_update_engine #(
    parameter int NUM_COL = 8,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [NUM_COL-1:0] wr_col_mask,
    input  logic [DEPTH-1:0]   wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [NUM_COL-1:0] rd_data,
    output logic [NUM_COL-1:0] q_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Count value of the final shift of a load; cnt never wraps past it.
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    // Serial bit presented on shift number cnt: MSB first, so the first bit
    // shifted in ends up at the deepest entry after DEPTH shifts.
    function automatic logic serial_bit(input logic [DEPTH-1:0]  word,
                                        input logic [ADDR_W-1:0] cnt);
        logic [ADDR_W-1:0] idx;
        idx = CNT_LAST - cnt;
        return word[idx];
    endfunction

    // Control state and registered status outputs.
    state_t               state_q,    state_d;
    logic [ADDR_W-1:0]    cnt_q,      cnt_d;
    logic [NUM_COL-1:0]   mask_q,     mask_d;
    logic [DEPTH-1:0]     buf_q,      buf_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    // Datapath towards the storage columns.
    logic [NUM_COL-1:0]   shift_en_s;
    logic                 din_s;

    // Storage: bit 0 is the newest entry, bit DEPTH-1 the cascade tap.
    // No reset, matching SRL primitives that come up zero after configuration.
    logic [DEPTH-1:0]     col_q [NUM_COL];

    // Next-state, latch and status computation for the load sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        buf_d      = buf_q;
        wr_ready_d = wr_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_valid && wr_ready_q) begin
                    // Request and mask are captured only here; later input
                    // changes have no effect on this load.
                    state_d    = ST_SHIFT;
                    mask_d     = wr_col_mask;
                    buf_d      = wr_data;
                    cnt_d      = '0;
                    wr_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    wr_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            ST_SHIFT: begin
                wr_ready_d = 1'b0;
                busy_d     = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // This edge performs the last shift (buf bit 0).
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                wr_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                wr_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Sequencer registers with synchronous reset; a mid-load reset abandons the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            buf_q      <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            buf_q      <= buf_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Column enables and serial bit; reset suppresses the shift on its own edge.
    always_comb begin
        shift_en_s = '0;
        din_s      = 1'b0;
        if ((state_q == ST_SHIFT) && !rst) begin
            shift_en_s = mask_q;
            din_s      = serial_bit(buf_q, cnt_q);
        end else begin
            shift_en_s = '0;
            din_s      = 1'b0;
        end
    end

    // Shift-register storage: enabled columns move one entry deeper per edge.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_COL; c++) begin
            if (shift_en_s[c]) begin
                col_q[c] <= {col_q[c][DEPTH-2:0], din_s};
            end
        end
    end

    // Read taps straight from storage (zero latency, not qualified by busy).
    always_comb begin
        rd_data = '0;
        q_last  = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            rd_data[c] = col_q[c][rd_addr];
            q_last[c]  = col_q[c][DEPTH-1];
        end
    end

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_srl_update_engine.sv
// Directed testbench for srl_update_engine: default 8x32 instance plus 1x32,
// 64x32 and 8x16 instances for the parameter sweep.
module tb_srl_update_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default 8 x 32 instance
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_col_mask;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  q_last;
    logic        busy;
    logic        done;

    // Expected column contents after each completed load
    logic [31:0] exp_col [8];

    srl_update_engine #(.NUM_COL(8), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_col_mask(wr_col_mask), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .q_last(q_last), .busy(busy), .done(done)
    );

    // Sweep instances
    logic        wr_valid_p;
    logic [31:0] data_p32;
    logic [4:0]  rd_addr_p32;
    logic [0:0]  mask1, rd1, ql1;
    logic        ready1, busy1, done1;
    logic [63:0] mask64, rd64, ql64;
    logic        ready64, busy64, done64;
    logic [7:0]  mask16, rd16, ql16;
    logic [15:0] data16;
    logic [3:0]  rd_addr16;
    logic        ready16, busy16, done16;

    srl_update_engine #(.NUM_COL(1), .DEPTH(32)) dut_c1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid_p), .wr_ready(ready1),
        .wr_col_mask(mask1), .wr_data(data_p32), .rd_addr(rd_addr_p32),
        .rd_data(rd1), .q_last(ql1), .busy(busy1), .done(done1)
    );

    srl_update_engine #(.NUM_COL(64), .DEPTH(32)) dut_c64 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid_p), .wr_ready(ready64),
        .wr_col_mask(mask64), .wr_data(data_p32), .rd_addr(rd_addr_p32),
        .rd_data(rd64), .q_last(ql64), .busy(busy64), .done(done64)
    );

    srl_update_engine #(.NUM_COL(8), .DEPTH(16)) dut_d16 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid_p), .wr_ready(ready16),
        .wr_col_mask(mask16), .wr_data(data16), .rd_addr(rd_addr16),
        .rd_data(rd16), .q_last(ql16), .busy(busy16), .done(done16)
    );

    // Sweep rd_addr over one column of the default instance.
    task automatic read_col(input int c, output logic [31:0] v);
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            #1;
            v[a] = rd_data[c];
        end
    endtask

    // Issue one load; lat = negedges from the handshake cycle to done (-1 on timeout).
    task automatic do_load(input logic [7:0] m, input logic [31:0] d, output int lat);
        int w;
        lat = -1;
        @(negedge clk);
        wr_valid    = 1'b1;
        wr_col_mask = m;
        wr_data     = d;
        w = 0;
        while (wr_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        wr_valid    = 1'b0;
        wr_col_mask = ~m;
        wr_data     = ~d;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        for (int c = 0; c < 8; c++) begin
            if (m[c]) exp_col[c] = d;
        end
    endtask

    task automatic test_reset;
        logic [7:0] acc;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got ready=%b busy=%b done=%b want 1 0 0", wr_ready, busy, done);
        end
        checks++;
        if (q_last !== 8'h00) begin
            errors++;
            $display("FAIL reset_q_last got %h want 00", q_last);
        end
        acc = 8'h00;
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            #1;
            acc = acc | rd_data;
            if (^rd_data === 1'bx) acc = 8'hxx;
        end
        checks++;
        if (acc !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data got %h want 00", acc);
        end
    endtask

    task automatic test_single_column;
        int          lat;
        logic [31:0] v;
        do_load(8'h01, 32'hA5C3_0F91, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL single_latency got %0d want 33", lat);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after_done got done=%b ready=%b busy=%b want 0 1 0", done, wr_ready, busy);
        end
        read_col(0, v);
        checks++;
        if (v !== 32'hA5C3_0F91) begin
            errors++;
            $display("FAIL single_col0 got %h want a5c30f91", v);
        end
        checks++;
        if (q_last !== 8'h01) begin
            errors++;
            $display("FAIL single_q_last got %h want 01", q_last);
        end
        for (int c = 1; c < 8; c++) begin
            read_col(c, v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL single_other_col%0d got %h want 00000000", c, v);
            end
        end
    endtask

    task automatic test_multi_column;
        int          lat;
        logic [31:0] v;
        logic [31:0] want;
        do_load(8'hFF, 32'hFFFF_FFFF, lat);
        do_load(8'hA0, 32'h0000_0001, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL multi_latency got %0d want 33", lat);
        end
        for (int c = 0; c < 8; c++) begin
            want = (c == 5 || c == 7) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            read_col(c, v);
            checks++;
            if (v !== want) begin
                errors++;
                $display("FAIL multi_col%0d got %h want %h", c, v, want);
            end
        end
    endtask

    task automatic test_back_to_back;
        int          w;
        int          k;
        int          lat;
        logic [31:0] v;
        @(negedge clk);
        wr_valid    = 1'b1;
        wr_col_mask = 8'h03;
        wr_data     = 32'h1357_9BDF;
        w = 0;
        while (wr_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        wr_col_mask = 8'h0C;
        wr_data     = 32'hFFFF_0000;
        k = 0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (k == 5) begin
                checks++;
                if (busy !== 1'b1 || wr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy got busy=%b ready=%b want 1 0", busy, wr_ready);
                end
            end
            if (k == 20) wr_data = 32'h2468_ACE0;
            if (wr_ready === 1'b1) break;
        end
        checks++;
        if (k !== 34) begin
            errors++;
            $display("FAIL b2b_accept_gap got %0d want 34", k);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_data  = 32'h0BAD_0BAD;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL b2b_second_latency got %0d want 33", lat);
        end
        exp_col[0] = 32'h1357_9BDF;
        exp_col[1] = 32'h1357_9BDF;
        exp_col[2] = 32'h2468_ACE0;
        exp_col[3] = 32'h2468_ACE0;
        for (int c = 0; c < 4; c++) begin
            read_col(c, v);
            checks++;
            if (v !== exp_col[c]) begin
                errors++;
                $display("FAIL b2b_col%0d got %h want %h", c, v, exp_col[c]);
            end
        end
    endtask

    task automatic test_zero_mask;
        int          lat;
        logic [31:0] v;
        do_load(8'h00, 32'hDEAD_BEEF, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL zero_mask_latency got %0d want 33", lat);
        end
        for (int c = 0; c < 8; c++) begin
            read_col(c, v);
            checks++;
            if (v !== exp_col[c]) begin
                errors++;
                $display("FAIL zero_mask_col%0d got %h want %h", c, v, exp_col[c]);
            end
        end
    endtask

    task automatic test_mid_reset;
        int          w;
        int          dn;
        int          lat;
        logic [31:0] v;
        @(negedge clk);
        wr_valid    = 1'b1;
        wr_col_mask = 8'h01;
        wr_data     = 32'hCAFE_F00D;
        w = 0;
        while (wr_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_status got ready=%b busy=%b done=%b want 1 0 0", wr_ready, busy, done);
        end
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL midrst_no_done got %0d pulses want 0", dn);
        end
        for (int c = 1; c < 8; c++) begin
            read_col(c, v);
            checks++;
            if (v !== exp_col[c]) begin
                errors++;
                $display("FAIL midrst_col%0d got %h want %h", c, v, exp_col[c]);
            end
        end
        do_load(8'h01, 32'h1234_5678, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL midrst_reload_latency got %0d want 33", lat);
        end
        read_col(0, v);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL midrst_reload_col0 got %h want 12345678", v);
        end
    endtask

    task automatic test_param_sweep;
        int          lat1, lat64, lat16;
        logic [31:0] v1, v64;
        logic [15:0] v16;
        logic [62:0] or64;
        logic [6:0]  or16;
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || ready64 !== 1'b1 || ready16 !== 1'b1) begin
            errors++;
            $display("FAIL sweep_ready got %b%b%b want 111", ready1, ready64, ready16);
        end
        wr_valid_p = 1'b1;
        mask1      = 1'b1;
        mask64     = 64'h1;
        data_p32   = 32'hA5C3_0F91;
        mask16     = 8'h01;
        data16     = 16'hBEEF;
        @(posedge clk);
        #1;
        wr_valid_p = 1'b0;
        data_p32   = 32'h0;
        data16     = 16'h0;
        lat1 = -1; lat64 = -1; lat16 = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done1 === 1'b1 && lat1 < 0)   lat1  = i;
            if (done64 === 1'b1 && lat64 < 0) lat64 = i;
            if (done16 === 1'b1 && lat16 < 0) lat16 = i;
        end
        checks++;
        if (lat1 !== 33) begin
            errors++;
            $display("FAIL sweep_c1_latency got %0d want 33", lat1);
        end
        checks++;
        if (lat64 !== 33) begin
            errors++;
            $display("FAIL sweep_c64_latency got %0d want 33", lat64);
        end
        checks++;
        if (lat16 !== 17) begin
            errors++;
            $display("FAIL sweep_d16_latency got %0d want 17", lat16);
        end
        or64 = '0;
        for (int a = 0; a < 32; a++) begin
            rd_addr_p32 = 5'(a);
            #1;
            v1[a]  = rd1[0];
            v64[a] = rd64[0];
            or64   = or64 | rd64[63:1];
        end
        checks++;
        if (v1 !== 32'hA5C3_0F91 || ql1 !== 1'b1) begin
            errors++;
            $display("FAIL sweep_c1_data got %h q_last=%b want a5c30f91 1", v1, ql1);
        end
        checks++;
        if (v64 !== 32'hA5C3_0F91 || ql64 !== 64'h1) begin
            errors++;
            $display("FAIL sweep_c64_data got %h q_last=%h want a5c30f91 0000000000000001", v64, ql64);
        end
        checks++;
        if (or64 !== 63'h0) begin
            errors++;
            $display("FAIL sweep_c64_others got %h want 0", or64);
        end
        or16 = '0;
        for (int a = 0; a < 16; a++) begin
            rd_addr16 = 4'(a);
            #1;
            v16[a] = rd16[0];
            or16   = or16 | rd16[7:1];
        end
        checks++;
        if (v16 !== 16'hBEEF || ql16 !== 8'h01 || or16 !== 7'h0) begin
            errors++;
            $display("FAIL sweep_d16_data got %h q_last=%h others=%h want beef 01 00", v16, ql16, or16);
        end
    endtask

    initial begin
        rst         = 1'b1;
        wr_valid    = 1'b0;
        wr_col_mask = 8'h00;
        wr_data     = 32'h0;
        rd_addr     = 5'd0;
        wr_valid_p  = 1'b0;
        data_p32    = 32'h0;
        rd_addr_p32 = 5'd0;
        mask1       = 1'b0;
        mask64      = 64'h0;
        mask16      = 8'h00;
        data16      = 16'h0;
        rd_addr16   = 4'd0;
        for (int c = 0; c < 8; c++) exp_col[c] = 32'h0;

        test_reset();
        test_single_column();
        test_multi_column();
        test_back_to_back();
        test_zero_mask();
        test_mid_reset();
        test_param_sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
